if_fetch_ctrl: RTL and testbench

IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

---
 rtl/if_fetch_ctrl.sv | 164 ++++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl.sv
// Instruction fetch controller: drives the I-memory request and feeds decode
// through an output register backed by a one-entry skid buffer.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        valid,
    output logic [31:0] inst,
    output logic [31:0] pc_plus4
);

    localparam logic [31:0] RST_PC = RESET_PC & ~32'd3;

    typedef enum logic [1:0] {
        RST,
        FETCH,
        HOLD,
        DISCARD
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] pc;
    logic [31:0] req_pc;
    logic [31:0] skid_inst;
    logic [31:0] skid_pc4;

    logic [31:0] br_pc;
    logic [31:0] pc_inc;
    logic        accept;

    logic        ld_out;
    logic        ld_skid;
    logic        mv_skid;
    logic        pc_step;
    logic        save_req;

    assign br_pc  = branch_addr & ~32'd3;
    assign pc_inc = pc + 32'd4;
    assign accept = !valid || !freeze;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RST: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                if (branch_taken) begin
                    state_nxt = mem_ready ? FETCH : DISCARD;
                end else if (mem_ready && !accept) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (branch_taken || !freeze) begin
                    state_nxt = FETCH;
                end
            end
            DISCARD: begin
                if (mem_ready) begin
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = RST;
            end
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_addr = pc;
        ld_out   = 1'b0;
        ld_skid  = 1'b0;
        mv_skid  = 1'b0;
        pc_step  = 1'b0;
        save_req = 1'b0;
        unique case (state)
            FETCH: begin
                mem_req = 1'b1;
                if (!branch_taken && mem_ready) begin
                    pc_step = 1'b1;
                    ld_out  = accept;
                    ld_skid = !accept;
                end
                save_req = branch_taken && !mem_ready;
            end
            HOLD: begin
                mv_skid = !branch_taken && !freeze;
            end
            DISCARD: begin
                // keep presenting the abandoned address until memory answers
                mem_req  = 1'b1;
                mem_addr = req_pc;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RST_PC;
            req_pc    <= RST_PC;
            valid     <= 1'b0;
            inst      <= 32'd0;
            pc_plus4  <= 32'd0;
            skid_inst <= 32'd0;
            skid_pc4  <= 32'd0;
        end else begin
            if (branch_taken) begin
                pc <= br_pc;
            end else if (pc_step) begin
                pc <= pc_inc;
            end

            if (save_req) begin
                req_pc <= pc;
            end

            if (branch_taken) begin
                valid <= 1'b0;
            end else if (ld_out) begin
                inst     <= mem_rdata;
                pc_plus4 <= pc_inc;
                valid    <= 1'b1;
            end else if (mv_skid) begin
                inst     <= skid_inst;
                pc_plus4 <= skid_pc4;
                valid    <= 1'b1;
            end else if (accept) begin
                valid <= 1'b0;
            end

            if (branch_taken) begin
                skid_inst <= 32'd0;
                skid_pc4  <= 32'd0;
            end else if (ld_skid) begin
                skid_inst <= mem_rdata;
                skid_pc4  <= pc_inc;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios plus a randomized run checked
// against an in-order instruction stream model and handshake rules.
module tb_if_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc_plus4;

    if_fetch_ctrl #(.RESET_PC(32'd0)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .valid        (valid),
        .inst         (inst),
        .pc_plus4     (pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          errors;
    int          waits_cfg;
    int          wcnt;
    bit          busy;
    int          consumed;
    logic [31:0] exp_pc;

    logic        p_rst;
    logic        p_freeze;
    logic        p_branch;
    logic        p_valid;
    logic        p_req;
    logic        p_ready;
    logic [31:0] p_addr;
    logic [31:0] p_inst;
    logic [31:0] p_pc4;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // memory answers with data equal to the address after wait states
    task automatic mem_drive();
        if (rst || mem_req !== 1'b1) begin
            busy      = 1'b0;
            mem_ready = 1'b0;
            mem_rdata = $urandom;
        end else begin
            if (!busy) begin
                busy = 1'b1;
                wcnt = (waits_cfg < 0) ? int'($urandom_range(2, 0)) : waits_cfg;
            end
            if (wcnt == 0) begin
                mem_ready = 1'b1;
                mem_rdata = mem_addr;
                busy      = 1'b0;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                wcnt--;
            end
        end
    endtask

    task automatic cyc();
        mem_drive();
        if (rst) begin
            exp_pc = 32'd0;
        end else if (branch_taken) begin
            exp_pc = branch_addr & ~32'd3;
        end else if (valid && !freeze) begin
            check("use_pc4", pc_plus4, exp_pc + 32'd4);
            check("use_inst", inst, exp_pc);
            exp_pc = exp_pc + 32'd4;
            consumed++;
        end
        p_rst    = rst;
        p_freeze = freeze;
        p_branch = branch_taken;
        p_valid  = valid;
        p_req    = mem_req;
        p_ready  = mem_ready;
        p_addr   = mem_addr;
        p_inst   = inst;
        p_pc4    = pc_plus4;
        @(posedge clk);
        @(negedge clk);
        if (p_rst) begin
            check("rst_req", {31'd0, mem_req}, 32'd0);
            check("rst_valid", {31'd0, valid}, 32'd0);
            check("rst_inst", inst, 32'd0);
            check("rst_pc4", pc_plus4, 32'd0);
        end else begin
            if (p_branch) begin
                check("br_flush", {31'd0, valid}, 32'd0);
            end else if (p_valid && p_freeze) begin
                check("frz_valid", {31'd0, valid}, 32'd1);
                check("frz_inst", inst, p_inst);
                check("frz_pc4", pc_plus4, p_pc4);
            end
            if (p_req && !p_ready) begin
                check("stall_req", {31'd0, mem_req}, 32'd1);
                check("stall_addr", mem_addr, p_addr);
            end
        end
        check("addr_align", {30'd0, mem_addr[1:0]}, 32'd0);
    endtask

    task automatic do_reset(input int waits);
        rst          = 1'b1;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'd0;
        waits_cfg    = waits;
        busy         = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        consumed     = 0;
        wcnt         = 0;
        busy         = 1'b0;
        exp_pc       = 32'd0;
        rst          = 1'b1;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'd0;
        mem_ready    = 1'b0;
        mem_rdata    = 32'd0;
        waits_cfg    = 0;

        // reset release, then zero-wait streaming
        do_reset(0);
        check("rel_req", {31'd0, mem_req}, 32'd1);
        check("rel_addr", mem_addr, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            check("zw_valid", {31'd0, valid}, 32'd1);
            check("zw_pc4", pc_plus4, 32'(4 * i));
        end

        // two wait states per fetch
        do_reset(2);
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < 3; k++) begin
                check("ws_addr", mem_addr, 32'(4 * n));
                cyc();
                if (k < 2) begin
                    check("ws_valid_lo", {31'd0, valid}, 32'd0);
                end else begin
                    check("ws_valid_hi", {31'd0, valid}, 32'd1);
                    check("ws_pc4", pc_plus4, 32'(4 * n + 4));
                end
            end
        end

        // freeze with inst=8 on the output
        do_reset(0);
        repeat (3) cyc();
        check("frz_pre", inst, 32'd8);
        freeze = 1'b1;
        cyc();
        check("frz_hold1", inst, 32'd8);
        check("frz_skid", dut.skid_inst, 32'd12);
        check("frz_noreq1", {31'd0, mem_req}, 32'd0);
        cyc();
        check("frz_hold2", inst, 32'd8);
        check("frz_noreq2", {31'd0, mem_req}, 32'd0);
        cyc();
        check("frz_hold3", inst, 32'd8);
        freeze = 1'b0;
        cyc();
        check("frz_out12", inst, 32'd12);
        cyc();
        check("frz_out16", inst, 32'd16);

        // branch while a 2-wait fetch of 0x20 is outstanding
        do_reset(0);
        branch_taken = 1'b1;
        branch_addr  = 32'h20;
        cyc();
        branch_taken = 1'b0;
        waits_cfg    = 2;
        check("bw_addr0", mem_addr, 32'h20);
        cyc();
        check("bw_addr1", mem_addr, 32'h20);
        branch_taken = 1'b1;
        branch_addr  = 32'hB8;
        cyc();
        branch_taken = 1'b0;
        check("bw_addr2", mem_addr, 32'h20);
        check("bw_req2", {31'd0, mem_req}, 32'd1);
        cyc();
        check("bw_drop", {31'd0, valid}, 32'd0);
        check("bw_new_addr", mem_addr, 32'hB8);
        begin
            int n;
            n = 0;
            while (!valid && n < 6) begin
                cyc();
                n++;
            end
        end
        check("bw_valid", {31'd0, valid}, 32'd1);
        check("bw_pc4", pc_plus4, 32'hBC);

        // branch beats freeze, low address bits dropped
        do_reset(0);
        cyc();
        cyc();
        check("pr_valid_pre", {31'd0, valid}, 32'd1);
        freeze       = 1'b1;
        branch_taken = 1'b1;
        branch_addr  = 32'h103;
        cyc();
        check("pr_valid", {31'd0, valid}, 32'd0);
        check("pr_addr", mem_addr, 32'h100);
        freeze       = 1'b0;
        branch_taken = 1'b0;
        cyc();
        check("pr_pc4", pc_plus4, 32'h104);

        // pc wrap at the top of the address space
        do_reset(0);
        branch_taken = 1'b1;
        branch_addr  = 32'hFFFF_FFF8;
        cyc();
        branch_taken = 1'b0;
        cyc();
        check("wr_pc4a", pc_plus4, 32'hFFFF_FFFC);
        cyc();
        check("wr_pc4b", pc_plus4, 32'd0);
        cyc();
        check("wr_inst", inst, 32'd0);

        // randomized mix of waits, freezes, branches and resets
        do_reset(-1);
        consumed = 0;
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(199, 0) == 0);
            freeze       = ($urandom_range(9, 0) < 3);
            branch_taken = !rst && ($urandom_range(19, 0) == 0);
            branch_addr  = ($urandom_range(3, 0) == 0) ?
                           (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) :
                           32'($urandom);
            cyc();
        end
        rst          = 1'b0;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        cyc();
        check("rand_progress", (consumed > 200) ? 32'd1 : 32'd0, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
